// File: rtl/inst_fetcher_pkg.sv
// Shared definitions for the instruction fetcher: opcodes, fetch state
// encoding, reset PC default and immediate-extraction helpers.
package inst_fetcher_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_t;

    function automatic logic [31:0] imm_b(input logic [31:0] word);
        return {{20{word[31]}}, word[7], word[30:25], word[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] word);
        return {{12{word[31]}}, word[19:12], word[20], word[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/inst_fetcher_predecode.sv
// Combinational next-PC predictor: branches and JAL are taken, everything
// else (JALR included, its target is register-based) falls through to pc+4.
module fetch_predecode
    import inst_fetcher_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [31:0]       word,
    input  logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] next_pc
);

    logic [ADDR_W-1:0] step;

    always_comb begin
        step = ADDR_W'(4);
        case (word[6:0])
            OP_BRANCH: step = ADDR_W'($signed(imm_b(word)));
            OP_JAL:    step = ADDR_W'($signed(imm_j(word)));
            OP_JALR, OP_AUIPC, OP_LOAD, OP_STORE, OP_LUI, OP_IMM:
                       step = ADDR_W'(4);
            default:   step = ADDR_W'(4);
        endcase
        next_pc = pc + step;
    end

endmodule

// File: rtl/inst_fetcher.sv
// Single-outstanding instruction fetcher feeding the issue queue.
// Optional FETCH_PERF_EN adds push and hold-stall counters.
module inst_fetcher
    import inst_fetcher_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              _clear,
    input  logic [ADDR_W-1:0] _clear_pc,
    output logic              _mem_req,
    output logic [ADDR_W-1:0] _mem_addr,
    input  logic              _mem_ready_in,
    input  logic [31:0]       _mem_data_in,
    input  logic              _need_inst,
    output logic              _inst_ready_out,
    output logic [31:0]       _inst_out,
    output logic [ADDR_W-1:0] _inst_addr_out
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       _perf_fetched,
    output logic [31:0]       _perf_stall
`endif
);

    fetch_state_t      state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic              discard_reg, discard_next;
    logic              mem_req_reg, mem_req_next;
    logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
    logic              inst_ready_reg, inst_ready_next;
    logic [31:0]       inst_reg, inst_next;
    logic [ADDR_W-1:0] inst_addr_reg, inst_addr_next;
    logic [31:0]       hold_word_reg, hold_word_next;
    logic [ADDR_W-1:0] hold_addr_reg, hold_addr_next;
    logic              hold_valid_reg, hold_valid_next;
    logic [ADDR_W-1:0] predict_pc;

    fetch_predecode #(
        .ADDR_W (ADDR_W)
    ) u_predecode (
        .word    (hold_word_reg),
        .pc      (hold_addr_reg),
        .next_pc (predict_pc)
    );

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_reg      <= S_IDLE;
            pc_reg         <= RESET_PC;
            discard_reg    <= 1'b0;
            mem_req_reg    <= 1'b0;
            mem_addr_reg   <= '0;
            inst_ready_reg <= 1'b0;
            inst_reg       <= '0;
            inst_addr_reg  <= '0;
            hold_word_reg  <= '0;
            hold_addr_reg  <= '0;
            hold_valid_reg <= 1'b0;
        end else if (rdy_in) begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            discard_reg    <= discard_next;
            mem_req_reg    <= mem_req_next;
            mem_addr_reg   <= mem_addr_next;
            inst_ready_reg <= inst_ready_next;
            inst_reg       <= inst_next;
            inst_addr_reg  <= inst_addr_next;
            hold_word_reg  <= hold_word_next;
            hold_addr_reg  <= hold_addr_next;
            hold_valid_reg <= hold_valid_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        discard_next    = discard_reg;
        mem_req_next    = mem_req_reg;
        mem_addr_next   = mem_addr_reg;
        inst_ready_next = 1'b0;
        inst_next       = inst_reg;
        inst_addr_next  = inst_addr_reg;
        hold_word_next  = hold_word_reg;
        hold_addr_next  = hold_addr_reg;
        hold_valid_next = hold_valid_reg;

        if (_clear) begin
            pc_next         = _clear_pc;
            hold_valid_next = 1'b0;
            // An in-flight request cannot be cancelled; let it finish and drop its word.
            if (state_reg == S_WAIT && !_mem_ready_in) begin
                discard_next = 1'b1;
            end else begin
                state_next   = S_IDLE;
                discard_next = 1'b0;
                mem_req_next = 1'b0;
            end
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (_need_inst) begin
                        mem_req_next  = 1'b1;
                        mem_addr_next = pc_reg;
                        state_next    = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (_mem_ready_in) begin
                        mem_req_next = 1'b0;
                        if (discard_reg) begin
                            discard_next = 1'b0;
                            state_next   = S_IDLE;
                        end else begin
                            hold_word_next  = _mem_data_in;
                            hold_addr_next  = mem_addr_reg;
                            hold_valid_next = 1'b1;
                            state_next      = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (_need_inst && hold_valid_reg) begin
                        inst_ready_next = 1'b1;
                        inst_next       = hold_word_reg;
                        inst_addr_next  = hold_addr_reg;
                        pc_next         = predict_pc;
                        hold_valid_next = 1'b0;
                        state_next      = S_IDLE;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    assign _mem_req        = mem_req_reg;
    assign _mem_addr       = mem_addr_reg;
    // A stalled global ready must not let the queue see the strobe twice.
    assign _inst_ready_out = inst_ready_reg & rdy_in;
    assign _inst_out       = inst_reg;
    assign _inst_addr_out  = inst_addr_reg;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_reg;
    logic [31:0] perf_stall_reg;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            perf_fetched_reg <= '0;
            perf_stall_reg   <= '0;
        end else if (rdy_in) begin
            if (inst_ready_next) begin
                perf_fetched_reg <= perf_fetched_reg + 32'd1;
            end
            if (state_reg == S_HOLD && !_need_inst) begin
                perf_stall_reg <= perf_stall_reg + 32'd1;
            end
        end
    end

    assign _perf_fetched = perf_fetched_reg;
    assign _perf_stall   = perf_stall_reg;
`endif

endmodule

// File: tb/tb_inst_fetcher.sv
// Directed bench for inst_fetcher with a fixed-latency memory model.
module tb_inst_fetcher;

    localparam int LAT = 3;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        _clear;
    logic [31:0] _clear_pc;
    logic        _mem_req;
    logic [31:0] _mem_addr;
    logic        _mem_ready_in;
    logic [31:0] _mem_data_in;
    logic        _need_inst;
    logic        _inst_ready_out;
    logic [31:0] _inst_out;
    logic [31:0] _inst_addr_out;
`ifdef FETCH_PERF_EN
    logic [31:0] _perf_fetched;
    logic [31:0] _perf_stall;
`endif

    int vec_cnt = 0;
    int err_cnt = 0;
    int bad_push = 0;
    logic [31:0] push_addr_q[$];
    logic [31:0] push_inst_q[$];
    logic [31:0] req_q[$];

    inst_fetcher dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        ._clear         (_clear),
        ._clear_pc      (_clear_pc),
        ._mem_req       (_mem_req),
        ._mem_addr      (_mem_addr),
        ._mem_ready_in  (_mem_ready_in),
        ._mem_data_in   (_mem_data_in),
        ._need_inst     (_need_inst),
        ._inst_ready_out(_inst_ready_out),
        ._inst_out      (_inst_out),
        ._inst_addr_out (_inst_addr_out)
`ifdef FETCH_PERF_EN
        ,
        ._perf_fetched  (_perf_fetched),
        ._perf_stall    (_perf_stall)
`endif
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        case (addr)
            32'h10:  return 32'h0080_006F;
            32'h20:  return 32'hFE00_0EE3;
            32'h30:  return 32'h0000_8067;
            default: return 32'h0000_0013;
        endcase
    endfunction

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, obs);
        end
    endtask

    // Memory: responds LAT cycles after seeing a new request, one-cycle ready pulse.
    initial begin : memory_model
        logic        busy;
        int          cnt;
        logic [31:0] cur_addr;
        busy = 1'b0; cnt = 0; cur_addr = '0;
        _mem_ready_in = 1'b0;
        _mem_data_in  = '0;
        forever begin
            @(posedge clk_in);
            #1;
            if (!rst_in) begin
                busy = 1'b0;
                _mem_ready_in = 1'b0;
            end else if (_mem_ready_in) begin
                _mem_ready_in = 1'b0;
            end else if (busy) begin
                cnt--;
                if (cnt == 0) begin
                    _mem_ready_in = 1'b1;
                    _mem_data_in  = mem_word(cur_addr);
                    busy = 1'b0;
                end
            end else if (_mem_req) begin
                busy = 1'b1;
                cnt = LAT;
                cur_addr = _mem_addr;
            end
        end
    end

    initial begin : monitor
        logic prev_req;
        prev_req = 1'b0;
        forever begin
            @(negedge clk_in);
            if (_inst_ready_out) begin
                push_addr_q.push_back(_inst_addr_out);
                push_inst_q.push_back(_inst_out);
                if (!_need_inst) bad_push++;
            end
            if (_mem_req && !prev_req) req_q.push_back(_mem_addr);
            prev_req = _mem_req;
        end
    end

    task automatic wait_pushes(input int n, input string tag);
        for (int i = 0; i < 300 && push_addr_q.size() < n; i++) begin
            @(negedge clk_in);
            #1;
        end
        check_vec(tag, push_addr_q.size(), n);
    endtask

    task automatic wait_reqs(input int n, input string tag);
        for (int i = 0; i < 300 && req_q.size() < n; i++) begin
            @(negedge clk_in);
            #1;
        end
        check_vec(tag, req_q.size(), n);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_vec({tag, "_mem_req"}, {31'd0, _mem_req}, 32'd0);
        check_vec({tag, "_mem_addr"}, _mem_addr, 32'd0);
        check_vec({tag, "_inst_ready"}, {31'd0, _inst_ready_out}, 32'd0);
        check_vec({tag, "_inst_out"}, _inst_out, 32'd0);
        check_vec({tag, "_inst_addr"}, _inst_addr_out, 32'd0);
    endtask

    initial begin : stimulus
        int bad;
        rst_in = 1'b0; rdy_in = 1'b1; _clear = 1'b0; _clear_pc = '0; _need_inst = 1'b0;
        repeat (3) @(negedge clk_in);
        #1;
        check_outputs_zero("reset_");
        @(negedge clk_in);
        rst_in = 1'b1;
        _need_inst = 1'b1;

        // Sequential addi stream.
        wait_pushes(3, "seq_push_count");
        check_vec("seq_push0_addr", push_addr_q[0], 32'h0);
        check_vec("seq_push1_addr", push_addr_q[1], 32'h4);
        check_vec("seq_push2_addr", push_addr_q[2], 32'h8);
        check_vec("seq_push0_inst", push_inst_q[0], 32'h0000_0013);
        check_vec("seq_req_count", req_q.size(), 3);
        check_vec("seq_req1_addr", req_q[1], 32'h4);

        // JAL +8 at 0x10.
        wait_pushes(6, "jal_push_count");
        check_vec("jal_push_addr", push_addr_q[4], 32'h10);
        check_vec("jal_push_inst", push_inst_q[4], 32'h0080_006F);
        check_vec("jal_target_push", push_addr_q[5], 32'h18);
        check_vec("jal_target_req", req_q[5], 32'h18);

        // Downstream full for 5 cycles while a word is held.
        wait_reqs(7, "stall_req_count");
        check_vec("stall_req_addr", req_q[6], 32'h1C);
        _need_inst = 1'b0;
        for (int i = 0; i < 50 && _mem_req; i++) begin
            @(negedge clk_in);
            #1;
        end
        check_vec("stall_hold_reached", {31'd0, _mem_req}, 32'd0);
        bad = 0;
        repeat (5) begin
            @(negedge clk_in);
            #1;
            if (_inst_ready_out || _mem_req) bad++;
        end
        check_vec("stall_quiet", bad, 0);
        _need_inst = 1'b1;
        @(negedge clk_in);
        #1;
        check_vec("stall_release_strobe", {31'd0, _inst_ready_out}, 32'd1);
        check_vec("stall_release_addr", _inst_addr_out, 32'h1C);
        check_vec("stall_push_count", push_addr_q.size(), 7);
`ifdef FETCH_PERF_EN
        check_vec("perf_stall", _perf_stall, 32'd5);
`endif

        // BEQ -4 at 0x20.
        wait_pushes(8, "beq_push_count");
        check_vec("beq_push_addr", push_addr_q[7], 32'h20);
        check_vec("beq_push_inst", push_inst_q[7], 32'hFE00_0EE3);
        wait_reqs(9, "beq_req_count");
        check_vec("beq_target_req", req_q[8], 32'h1C);

        // Redirect while the 0x1C fetch is in flight.
        _clear = 1'b1;
        _clear_pc = 32'h100;
        @(posedge clk_in);
        #1;
        _clear = 1'b0;
        check_vec("clear_keeps_req", {31'd0, _mem_req}, 32'd1);
        check_vec("clear_keeps_addr", _mem_addr, 32'h1C);
        wait_reqs(10, "clear_req_count");
        check_vec("clear_req_addr", req_q[9], 32'h100);
        check_vec("clear_dropped", push_addr_q.size(), 8);
        wait_pushes(9, "clear_push_count");
        check_vec("clear_push_addr", push_addr_q[8], 32'h100);

        // Redirect from idle to the JALR at 0x30.
        _clear = 1'b1;
        _clear_pc = 32'h30;
        @(posedge clk_in);
        #1;
        _clear = 1'b0;
        wait_reqs(11, "jalr_req_count");
        check_vec("jalr_req_addr", req_q[10], 32'h30);
        wait_pushes(10, "jalr_push_count");
        check_vec("jalr_push_addr", push_addr_q[9], 32'h30);
        check_vec("jalr_push_inst", push_inst_q[9], 32'h0000_8067);
        wait_reqs(12, "jalr_next_req_count");
        check_vec("jalr_next_req", req_q[11], 32'h34);
`ifdef FETCH_PERF_EN
        check_vec("perf_fetched", _perf_fetched, 32'd10);
`endif

        // Asynchronous reset in the middle of S_WAIT.
        #2;
        rst_in = 1'b0;
        #1;
        check_outputs_zero("async_rst_");
`ifdef FETCH_PERF_EN
        check_vec("perf_fetched_rst", _perf_fetched, 32'd0);
`endif
        @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b1;
        wait_reqs(13, "rst_req_count");
        check_vec("rst_req_addr", req_q[12], 32'h0);
        wait_pushes(11, "rst_push_count");
        check_vec("rst_push_addr", push_addr_q[10], 32'h0);
        check_vec("no_push_without_need", bad_push, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/inst_fetcher.md
Name: inst_fetcher

Overview:
- Front-end stage directly upstream of the issue queue.
- Holds the PC and issues one 32-bit instruction-fetch request at a time to the instruction memory port.
- Pre-decodes each returned word to pick the next PC: B-type and JAL predicted taken, everything else PC+4.
- Pushes (instruction, address) pairs downstream while the issue queue asserts need_inst. Redirects to a new PC on _clear from the ROB.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- ADDR_W, 32, width of PC and memory address.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  asynchronous, active-low reset
- rdy_in  in  1  global ready; when low all state holds
- _clear  in  1  pipeline flush (ROB mispredict/redirect)
- _clear_pc  in  32  redirect target, valid with _clear
- _mem_req  out  1  fetch request, level, held until _mem_ready_in
- _mem_addr  out  32  fetch address, stable while _mem_req=1
- _mem_ready_in  in  1  one-cycle pulse, data valid
- _mem_data_in  in  32  fetched word
- _need_inst  in  1  downstream queue not full
- _inst_ready_out  out  1  one-cycle push strobe to issue queue
- _inst_out  out  32  instruction word
- _inst_addr_out  out  32  instruction address

Behaviour:
- Reset (rst_in=0, async): pc=RESET_PC, state=S_IDLE, discard=0, _mem_req=0, _mem_addr=0, _inst_ready_out=0, _inst_out=0, _inst_addr_out=0.
- rdy_in=0: no state or register update. _inst_ready_out is forced to 0 that cycle.
- States:
  - S_IDLE: if _need_inst, then _mem_req<=1, _mem_addr<=pc, go S_WAIT.
  - S_WAIT: on _mem_ready_in, _mem_req<=0.
    - discard=1: drop the word, discard<=0, go S_IDLE.
    - discard=0: latch word and address into hold regs, go S_HOLD.
  - S_HOLD: if _need_inst, then _inst_ready_out<=1 for exactly one cycle with _inst_out/_inst_addr_out, pc<=next_pc, go S_IDLE. Otherwise wait.
- next_pc (pre-decode, computed from the held word):
  - opcode 1100011: pc + sext(immB).
  - opcode 1101111: pc + sext(immJ).
  - all other opcodes, including 1100111 JALR and 0010111 AUIPC: pc+4.
  - Arithmetic is mod 2^32 and wraps silently.
- _clear, highest priority, any state:
  - pc<=_clear_pc, _inst_ready_out<=0, hold regs invalidated.
  - In S_WAIT with _mem_ready_in=0: keep _mem_req=1 (the memory transaction must complete), set discard=1, stay S_WAIT.
  - _clear coincident with _mem_ready_in: the word is dropped, go S_IDLE.
  - In S_IDLE/S_HOLD: go S_IDLE.
  - The new fetch starts no earlier than the cycle after _clear.
- Throughput: at most one instruction per memory latency + 2 cycles. Never more than one outstanding request.
- A push is never issued while _need_inst=0. No instruction is ever duplicated or lost absent _clear.

Optional Feature:
- FETCH_PERF_EN
- Defined: adds outputs _perf_fetched (32) and _perf_stall (32).
  - _perf_fetched counts pushes.
  - _perf_stall counts cycles in S_HOLD with _need_inst=0.
  - Both reset to 0, wrap at 2^32, and are not cleared by _clear.
- Undefined: ports and counters absent. Functional behaviour identical.

Decomposition:
- Shared package: opcode constants (OP_BRANCH 7'b1100011, OP_JAL 7'b1101111, OP_JALR 7'b1100111, OP_AUIPC 7'b0010111, OP_LOAD, OP_STORE, OP_LUI, OP_IMM), fetch state encoding, RESET_PC default.
- One sub-module: fetch_predecode, purely combinational. Inputs: word, pc. Output: next_pc, using the immB/immJ extraction.

Test Plan:
- Reset release, RESET_PC=0, memory latency 3, word 0x00000013 (addi), _need_inst=1 → _mem_addr=0 then 4; pushes addr 0, 4, 8 with one strobe per fetch.
- Word 0x0080006F (jal x0,+8) at pc 0x10 → pushed with addr 0x10; next _mem_addr=0x18.
- Word 0xFE000EE3 (beq x0,x0,-4) at pc 0x20 → next _mem_addr=0x1C. JALR 0x00008067 at 0x30 → next 0x34.
- _need_inst=0 with word held for 5 cycles → no strobe, _mem_req stays 0; strobe the cycle after _need_inst returns high. With FETCH_PERF_EN, _perf_stall=5.
- _clear with _clear_pc=0x100 while waiting → in-flight word dropped, no strobe; next request at 0x100, first push addr 0x100.
- Assert rst_in=0 mid S_WAIT → all outputs 0 immediately (async); after release, fetch restarts at RESET_PC.
